// File: rtl/act_unit_pipe.sv
// Multi-lane float32 activation unit (identity / ReLU / hard-tanh / leaky ReLU)
// with a 2-stage valid/ready pipeline and a saturating hard-tanh clamp counter.
module act_unit_pipe #(
  parameter int DATAWIDTH  = 32,
  parameter int NUM_CH     = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_mode,
  input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*DATAWIDTH-1:0] out_data,
  output logic [CNT_W-1:0]            sat_count,
  input  logic                        clr_cnt
);

  localparam int               EW      = 5;
  localparam int               SW      = CNT_W + EW;
  localparam logic [7:0]       LS      = 8'(LEAK_SHIFT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                        r_s1_valid;
  logic [1:0]                  r_s1_mode;
  logic [NUM_CH-1:0]           r_s1_sign;
  logic [NUM_CH-1:0]           r_s1_nan;
  logic [NUM_CH-1:0]           r_s1_den;
  logic [NUM_CH-1:0][7:0]      r_s1_exp;
  logic [NUM_CH-1:0][22:0]     r_s1_mant;
  logic                        r_s2_valid;
  logic [NUM_CH*DATAWIDTH-1:0] r_s2_data;
  logic [CNT_W-1:0]            r_sat;

  logic                        w_s1_adv;
  logic                        w_s2_adv;
  logic [NUM_CH*DATAWIDTH-1:0] w_result;
  logic [NUM_CH-1:0]           w_evt;
  logic [EW-1:0]               w_evt_cnt;
  logic [SW-1:0]               w_sum;

  function automatic logic [31:0] f_lane(input logic [1:0] mode, input logic s,
                                         input logic [7:0] e, input logic [22:0] m,
                                         input logic nan, input logic den);
    logic [31:0] x;
    x      = den ? {s, 31'b0} : {s, e, m};
    f_lane = x;
    if (nan) begin
      f_lane = 32'h7FC00000;
    end else begin
      case (mode)
        2'd1: if (s) f_lane = 32'h00000000;
        2'd2: if (e >= 8'd127) f_lane = s ? 32'hBF800000 : 32'h3F800000;
        // A flushed denormal has e=0, so it falls into the underflow branch.
        2'd3: if (s) begin
                if (e == 8'hFF)    f_lane = 32'hFF800000;
                else if (e <= LS)  f_lane = 32'h80000000;
                else               f_lane = {s, e - LS, m};
              end
        default: f_lane = x;
      endcase
    end
  endfunction

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign sat_count = r_sat;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= '0;
      r_s1_sign  <= '0;
      r_s1_nan   <= '0;
      r_s1_den   <= '0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= in_mode;
        for (int k = 0; k < NUM_CH; k++) begin
          r_s1_sign[k] <= in_data[DATAWIDTH*k + 31];
          r_s1_exp[k]  <= in_data[DATAWIDTH*k + 23 +: 8];
          r_s1_mant[k] <= in_data[DATAWIDTH*k +: 23];
          r_s1_nan[k]  <= (in_data[DATAWIDTH*k + 23 +: 8] == 8'hFF) &&
                          (in_data[DATAWIDTH*k +: 23] != 23'd0);
          r_s1_den[k]  <= (in_data[DATAWIDTH*k + 23 +: 8] == 8'h00) &&
                          (in_data[DATAWIDTH*k +: 23] != 23'd0);
        end
      end
    end
  end

  always_comb begin
    w_result  = '0;
    w_evt     = '0;
    w_evt_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_result[DATAWIDTH*k +: DATAWIDTH] = f_lane(r_s1_mode, r_s1_sign[k], r_s1_exp[k],
                                                  r_s1_mant[k], r_s1_nan[k], r_s1_den[k]);
      // Only |x| > 1.0 counts; exactly +-1.0 passes through unclamped in effect.
      w_evt[k] = (r_s1_mode == 2'd2) && !r_s1_nan[k] &&
                 ((r_s1_exp[k] > 8'd127) ||
                  ((r_s1_exp[k] == 8'd127) && (r_s1_mant[k] != 23'd0)));
      w_evt_cnt = w_evt_cnt + EW'(w_evt[k]);
    end
  end

  assign w_sum = SW'(r_sat) + SW'(w_evt_cnt);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_data <= w_result;
    end
  end

  // Clear takes priority: events landing in the clear cycle are discarded.
  always_ff @(posedge clk) begin
    if (!reset_n || clr_cnt) begin
      r_sat <= '0;
    end else if (r_s1_valid && w_s2_adv) begin
      r_sat <= (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Scoreboard bench for act_unit_pipe: expected beats are queued on acceptance
// and compared when the unit hands them downstream.
module tb_act_unit_pipe;
  localparam int NCH   = 4;
  localparam int DW    = NCH * 32;
  localparam int CNT_W = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [CNT_W-1:0] sat_count;
  logic           clr_cnt;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  act_unit_pipe #(.DATAWIDTH(32), .NUM_CH(NCH), .LEAK_SHIFT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_count(sat_count), .clr_cnt(clr_cnt)
  );

  function automatic logic [DW-1:0] pack(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] model_lane(input logic [1:0] mode, input logic [31:0] xin);
    logic [31:0] x;
    logic s;
    logic [7:0] e;
    logic [22:0] m;
    x = xin; s = x[31]; e = x[30:23]; m = x[22:0];
    if (e == 8'hFF && m != 0) return 32'h7FC00000;
    if (e == 8'h00 && m != 0) begin x = {s, 31'b0}; m = '0; end
    case (mode)
      2'd0: return x;
      2'd1: return s ? 32'h00000000 : x;
      2'd2: return (e >= 8'd127) ? (s ? 32'hBF800000 : 32'h3F800000) : x;
      default: begin
        if (!s) return x;
        if (e == 8'hFF) return 32'hFF800000;
        if (e <= 8'd3) return 32'h80000000;
        return {1'b1, e - 8'd3, m};
      end
    endcase
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [1:0] mode, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) r[32*k +: 32] = model_lane(mode, d[32*k +: 32]);
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_mode = 2'd0; in_data = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    else if (0) ; if (out_valid !== 1'b0) errors++;
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (sat_count !== '0) begin errors++; $display("[TB] FAIL reset_sat_count: got %0d want 0", sat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_modes();
    logic [DW-1:0] din[4];
    logic [DW-1:0] dexp[4];
    int satexp[4];
    logic [DW-1:0] want;
    din[0]  = pack(32'hBF000000, 32'h3F000000, 32'h00000000, 32'h3E4CCCCD);
    dexp[0] = din[0];
    din[1]  = pack(32'hBF000000, 32'h3E99999A, 32'hFF800000, 32'h80000000);
    dexp[1] = pack(32'h00000000, 32'h3E99999A, 32'h00000000, 32'h00000000);
    din[2]  = pack(32'h40000000, 32'hC0400000, 32'h3F800000, 32'hBF000000);
    dexp[2] = pack(32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF000000);
    din[3]  = pack(32'hBF000000, 32'h3F000000, 32'h80000001, 32'h7FC00001);
    dexp[3] = pack(32'hBD800000, 32'h3F000000, 32'h80000000, 32'h7FC00000);
    satexp = '{0, 0, 2, 2};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = 2'(t); in_data = din[t]; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mode%0d_in_ready: got %b want 1", t, in_ready); end
      sb_q.push_back(dexp[t]);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mode%0d_early_valid: got %b want 0", t, out_valid); end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL mode%0d_latency: out_valid got %b want 1", t, out_valid);
      end else begin
        want = sb_q.pop_front();
        checks++;
        if (out_data !== want) begin errors++; $display("[TB] FAIL mode%0d_data: got %h want %h", t, out_data, want); end
      end
      checks++;
      if (sat_count !== 16'(satexp[t])) begin errors++; $display("[TB] FAIL mode%0d_sat_count: got %0d want %0d", t, sat_count, satexp[t]); end
    end
    sb_q.delete();
  endtask

  task automatic test_clr_cnt();
    logic [DW-1:0] want;
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'd2; in_data = {NCH{32'h40000000}}; out_ready = 1'b1;
    sb_q.push_back({NCH{32'h3F800000}});
    @(negedge clk);
    in_valid = 1'b0; clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    #1;
    checks++; if (sat_count !== '0) begin errors++; $display("[TB] FAIL clr_same_cycle: got %0d want 0", sat_count); end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_out_valid: got %b want 1", out_valid);
    end else begin
      want = sb_q.pop_front();
      checks++; if (out_data !== want) begin errors++; $display("[TB] FAIL clr_data: got %h want %h", out_data, want); end
    end
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] beats[6];
    int pat[4];
    int sent, rcvd, cyc;
    logic saw_block, held;
    logic [DW-1:0] held_data, want;
    pat = '{1, 0, 0, 1};
    sent = 0; rcvd = 0; cyc = 0; saw_block = 1'b0; held = 1'b0; held_data = '0;
    for (int b = 0; b < 6; b++) beats[b] = {$urandom, $urandom, $urandom, $urandom};
    while ((sent < 6 || rcvd < 6) && cyc < 60) begin
      @(negedge clk);
      out_ready = (pat[cyc % 4] != 0);
      in_valid = (sent < 6);
      if (sent < 6) begin in_mode = 2'(sent % 4); in_data = beats[sent]; end
      #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          errors++; $display("[TB] FAIL stall_hold: got %b/%h want 1/%h", out_valid, out_data, held_data);
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("[TB] FAIL stream_extra: got beat %h want none", out_data);
        end else begin
          want = sb_q.pop_front();
          if (out_data !== want) begin errors++; $display("[TB] FAIL stream_beat%0d: got %h want %h", rcvd, out_data, want); end
        end
        rcvd++;
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        sb_q.push_back(model_beat(2'(sent % 4), beats[sent]));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (sent != 6 || rcvd != 6) begin errors++; $display("[TB] FAIL stream_count: got sent=%0d rcvd=%0d want 6/6", sent, rcvd); end
    checks++; if (saw_block !== 1'b1) begin errors++; $display("[TB] FAIL stream_backpressure: in_ready never dropped, want drop"); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("[TB] FAIL stream_leftover: got %0d queued want 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_midstream_reset();
    logic [DW-1:0] cbeat, want;
    cbeat = pack(32'h3F000000, 32'hC1200000, 32'h00000000, 32'h42280000);
    @(negedge clk);
    clr_cnt = 1'b1; in_valid = 1'b1; in_mode = 2'd2; in_data = {NCH{32'h40000000}}; out_ready = 1'b0;
    @(negedge clk);
    clr_cnt = 1'b0; in_data = {NCH{32'hC0000000}};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || sat_count !== 16'd4) begin
      errors++; $display("[TB] FAIL prereset_state: got valid=%b cnt=%0d want 1/4", out_valid, sat_count);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b1; in_mode = 2'd0; in_data = cbeat; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b want 0", out_valid); end
    checks++; if (sat_count !== '0) begin errors++; $display("[TB] FAIL midreset_sat: got %0d want 0", sat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready: got %b want 1", in_ready); end
    sb_q.delete();
    sb_q.push_back(cbeat);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ghost: got %b want 0", out_valid); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL postreset_latency: got %b want 1", out_valid);
    end else begin
      want = sb_q.pop_front();
      checks++; if (out_data !== want) begin errors++; $display("[TB] FAIL postreset_data: got %h want %h", out_data, want); end
    end
    sb_q.delete();
  endtask

  task automatic test_saturation();
    int acc, cyc;
    @(negedge clk);
    clr_cnt = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 16384 && cyc < 20000) begin
      in_valid = 1'b1; in_mode = 2'd2; in_data = {NCH{32'h40000000}};
      #1;
      if (in_ready) acc++;
      cyc++;
      if (acc == 16383) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (sat_count !== 16'd65532) begin errors++; $display("[TB] FAIL sat_near_max: got %0d want 65532", sat_count); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (acc != 16384) begin errors++; $display("[TB] FAIL sat_timeout: got %0d beats want 16384", acc); end
    checks++; if (sat_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_clamp: got %0d want 65535", sat_count); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_clr_cnt();
    test_back_to_back();
    test_midstream_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/act_unit_pipe.md
Name: act_unit_pipe

Overview:
- Parametrised, multi-channel, multi-mode IEEE-754 single-precision activation unit for the CNN datapath, one generation beyond the single-lane float32 tanh block.
- Processes NUM_CH float32 lanes per beat through a 2-stage valid/ready pipeline with full backpressure.
- Supports a runtime mode per beat: identity, ReLU, hard-tanh (clamp to ±1.0) and leaky ReLU.
- Counts saturation events for the debug path. Sits between the convolution/accumulate stage and the pooling stage.

Parameters:
- DATAWIDTH, 32, element width; fixed at 32, binary32 only.
- NUM_CH, 4, lanes per beat; legal range 1..16.
- LEAK_SHIFT, 3, leaky-ReLU negative slope is 2^-LEAK_SHIFT; legal range 1..8.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous reset, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat this cycle
- in_mode  in  2  0 identity, 1 ReLU, 2 hard-tanh, 3 leaky ReLU; sampled with the beat
- in_data  in  NUM_CH*32  lane k occupies bits [32k+31:32k]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_CH*32  results, same lane packing
- sat_count  out  CNT_W  hard-tanh clamp events, saturating
- clr_cnt  in  1  synchronous clear of sat_count

Behaviour:
- Reset (reset_n=0 at a clk edge): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, sat_count=0, in_ready=1 in the following cycle. Reset mid-stream discards in-flight beats without producing output.
- Pipeline stages:
  - S1 registers the data, the mode, and per-lane decode (sign, exp, mant, NaN, denormal).
  - S2 registers the result; out_data and out_valid come from S2.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational)
- A beat is accepted when in_valid & in_ready. out_valid rises 2 cycles after acceptance with no stall. Throughput is 1 beat/cycle.
- While out_valid=1 & out_ready=0, out_data holds stable and no beat is lost or duplicated.
- Per-lane rules (s=sign, e=exp[30:23], m=mant[22:0]), applied first for every mode:
  - NaN (e=255, m≠0) -> canonical 32'h7FC00000.
  - Denormal (e=0, m≠0) -> flushed to signed zero {s,31'b0} before the mode rule.
- Mode 0, identity: output x.
- Mode 1, ReLU: s=1 -> 32'h00000000 (including -0 and -inf); else x.
- Mode 2, hard-tanh:
  - e≥127 -> s ? 32'hBF800000 : 32'h3F800000 (±inf included); else x.
  - A clamp event is |x|>1.0, i.e. e>127 or (e=127 & m≠0). Exactly ±1.0 is not an event.
- Mode 3, leaky ReLU:
  - s=0 -> x.
  - s=1, e=255 -> -inf.
  - s=1, e≤LEAK_SHIFT -> 32'h80000000 (underflow flushed).
  - Otherwise exponent becomes e-LEAK_SHIFT; sign and mantissa unchanged.
- sat_count:
  - Adds the number of lanes with a clamp event in the beat, when that beat moves S1->S2.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt=1 zeroes the count that cycle; events arriving in the same cycle are dropped.

Test Plan:
- Identity, NUM_CH=4, lanes {BF000000,3F000000,00000000,3E4CCCCD}, out_ready=1 -> identical beat on out_valid exactly 2 cycles later.
- ReLU, lanes {BF000000,3E99999A,FF800000,80000000} -> {00000000,3E99999A,00000000,00000000}.
- Hard-tanh, lanes {40000000,C0400000,3F800000,BF000000} -> {3F800000,BF800000,3F800000,BF000000}; sat_count +2.
- Leaky ReLU with LEAK_SHIFT=3, lanes {BF000000,3F000000,80000001,7FC00001} -> {BD800000,3F000000,80000000,7FC00000}.
- Backpressure: stream 6 beats with in_valid=1 while out_ready toggles 1,0,0,1 -> in_ready drops after 2 beats are held; all 6 beats arrive in order, none lost or duplicated; out_data stable while stalled.
- Reset mid-stream with 2 beats in flight -> out_valid=0 and sat_count=0 the next cycle; the first post-reset beat appears after 2 cycles.
